// File: rtl/drain_pkg.sv
// drain_pkg: shared widths and FSM state encoding for the staging-buffer drain path
// No ports; imported by sram_drain_ctrl and lane_adder_tree.
package drain_pkg;
  localparam int SRAM_BIT = 128;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;
  localparam int LANE_W = 16;
  localparam int LANES = SRAM_BIT / LANE_W;
  localparam int SUM_W = LANE_W + 3;
  localparam int TOT_W = SUM_W + 3;
  typedef enum logic [2:0] {IDLE, RD, CAP, OUT, DONE} state_e;
endpackage

// File: rtl/lane_adder_tree.sv
// lane_adder_tree: combinational signed adder tree over the packed lanes of one word
// lanes_i : LANES*LANE_W packed lanes, lane i at [i*LANE_W +: LANE_W]
// sum_o   : signed sum of all lanes, SUM_W bits
module lane_adder_tree import drain_pkg::*; #(
  parameter int LANES = 8,
  parameter int LANE_W = 16,
  parameter int SUM_W = LANE_W + $clog2(LANES)
) (
  input  logic [LANES*LANE_W-1:0] lanes_i,
  output logic signed [SUM_W-1:0] sum_o
);
  // Heap-ordered tree: leaves at LANES-1.., node n sums children 2n+1 and 2n+2.
  logic signed [SUM_W-1:0] node [2*LANES-1];
  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node[LANES-1+i] = SUM_W'($signed(lanes_i[i*LANE_W +: LANE_W]));
  end
  for (genvar i = 0; i < LANES-1; i++) begin : g_node
    assign node[i] = node[2*i+1] + node[2*i+2];
  end
  assign sum_o = node[0];
endmodule

// File: rtl/sram_drain_ctrl.sv
// sram_drain_ctrl: drains the 8-slot staging buffer into a valid/ready stream with lane sums
// CLK, rst            : clock, synchronous active-high reset
// en, full            : start a drain when both are high in IDLE
// sram_cen/wen/a/q    : buffer read port (cen active-low, wen tied high, q one cycle after read)
// out_data/sum/valid/ready : drained word, its lane sum, handshake
// tot_sum, drain_done : batch total, valid during the one-cycle done pulse
// drain_busy          : high outside IDLE; stalls the upstream writer
module sram_drain_ctrl import drain_pkg::*; #(
  parameter int SRAM_BIT = drain_pkg::SRAM_BIT,
  parameter int DEPTH = drain_pkg::DEPTH,
  parameter int ADDR_W = drain_pkg::ADDR_W,
  parameter int LANE_W = drain_pkg::LANE_W,
  parameter int SUM_W = LANE_W + 3,
  parameter int TOT_W = SUM_W + 3
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                en,
  input  logic                full,
  input  logic [SRAM_BIT-1:0] sram_q,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [SRAM_BIT-1:0] out_data,
  output logic [SUM_W-1:0]    out_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TOT_W-1:0]    tot_sum,
  output logic                drain_busy,
  output logic                drain_done
);
  localparam int LN = SRAM_BIT / LANE_W;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic signed [TOT_W-1:0] acc_q, acc_d;
  logic [SRAM_BIT-1:0] data_q, data_d;
  logic signed [SUM_W-1:0] sum_q, sum_d, lane_sum;
  logic last;
  lane_adder_tree #(.LANES(LN), .LANE_W(LANE_W), .SUM_W(SUM_W)) u_tree (
    .lanes_i(sram_q),
    .sum_o(lane_sum)
  );
  assign last = idx_q == ADDR_W'(DEPTH - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    data_d = data_q;
    sum_d = sum_q;
    case (state_q)
      IDLE: if (en && full) begin
        state_d = RD;
        idx_d = '0;
        acc_d = '0;
      end
      RD: state_d = CAP;
      CAP: begin
        state_d = OUT;
        data_d = sram_q;
        sum_d = lane_sum;
        acc_d = acc_q + TOT_W'(lane_sum);
      end
      OUT: if (out_ready) begin
        state_d = last ? DONE : RD;
        idx_d = last ? idx_q : idx_q + ADDR_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      data_q <= '0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      data_q <= data_d;
      sum_q <= sum_d;
    end
  end
  assign sram_cen = state_q != RD;
  assign sram_wen = 1'b1;
  assign sram_a = idx_q;
  assign out_data = data_q;
  assign out_sum = sum_q;
  assign out_valid = state_q == OUT;
  assign tot_sum = state_q == DONE ? acc_q : '0;
  assign drain_busy = state_q != IDLE;
  assign drain_done = state_q == DONE;
endmodule

// File: tb/tb_sram_drain_ctrl.sv
// tb_sram_drain_ctrl: directed table-driven bench for sram_drain_ctrl
module tb_sram_drain_ctrl;
  typedef struct { logic [127:0] word; logic [18:0] sum; } vec_t;
  logic CLK = 0, rst = 1, en = 0, full = 0, out_ready = 1;
  logic [127:0] sram_q = '0;
  logic sram_cen, sram_wen, out_valid, drain_busy, drain_done;
  logic [2:0] sram_a;
  logic [127:0] out_data;
  logic [18:0] out_sum;
  logic [21:0] tot_sum;
  logic [127:0] mem [8];
  vec_t tbl [24];
  logic [21:0] tot [3];
  int cyc = 0, n_chk = 0, n_err = 0;
  sram_drain_ctrl dut (
    .CLK(CLK), .rst(rst), .en(en), .full(full), .sram_q(sram_q),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
    .out_data(out_data), .out_sum(out_sum), .out_valid(out_valid), .out_ready(out_ready),
    .tot_sum(tot_sum), .drain_busy(drain_busy), .drain_done(drain_done)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (!sram_cen) sram_q <= mem[sram_a];
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic fill(input int b);
    for (int k = 0; k < 8; k++) mem[k] = tbl[b*8+k].word;
  endtask
  task automatic chk_reset_outs(input string nm);
    chk({nm, "_cen"}, sram_cen, 1);
    chk({nm, "_wen"}, sram_wen, 1);
    chk({nm, "_addr"}, sram_a, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_sum"}, out_sum, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_tot"}, tot_sum, 0);
    chk({nm, "_busy"}, drain_busy, 0);
    chk({nm, "_done"}, drain_done, 0);
  endtask
  task automatic start(input int b);
    fill(b);
    full = 1;
    en = 1;
    step;
    chk("start_rd", sram_cen, 0);
    chk("start_addr", sram_a, 0);
  endtask
  task automatic chk_idle;
    step;
    chk("idle_busy", drain_busy, 0);
    chk("idle_done", drain_done, 0);
    chk("idle_tot", tot_sum, 0);
  endtask
  // Entered at #1 in the first RD cycle; returns at #1 in the DONE cycle
  // (or a few cycles after a reset injected on word rst_k).
  task automatic run_batch(input int b, input int sk, input int sl, input int rst_k, input bit drop_en);
    int t0, extra, n;
    t0 = cyc;
    extra = 0;
    full = 0;
    if (drop_en) en = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        chk("rd_cen", sram_cen, 0);
        chk("rd_addr", sram_a, k);
        chk("rd_time", cyc, t0 + 3*k + extra);
      end
      out_ready = (k != sk);
      n = 0;
      do begin
        step;
        n++;
      end while (!out_valid && n < 20);
      chk("valid", out_valid, 1);
      chk("data", out_data, tbl[b*8+k].word);
      chk("sum", out_sum, tbl[b*8+k].sum);
      chk("cen_out", sram_cen, 1);
      if (k == rst_k) begin
        rst = 1;
        step;
        chk_reset_outs("mid_rst");
        rst = 0;
        repeat (4) begin
          step;
          chk("rst_no_done", drain_done, 0);
          chk("rst_no_rd", sram_cen, 1);
        end
        return;
      end
      if (k == sk) begin
        repeat (sl) begin
          step;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, tbl[b*8+k].word);
          chk("stall_sum", out_sum, tbl[b*8+k].sum);
          chk("stall_cen", sram_cen, 1);
        end
        out_ready = 1;
        extra = sl;
      end
      step;
    end
    chk("done", drain_done, 1);
    chk("tot", tot_sum, tot[b]);
    chk("done_time", cyc, t0 + 24 + extra);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{ {8{16'h0001}}, 19'd8 };
    tbl[1] = '{ {8{16'h0002}}, 19'd16 };
    tbl[2] = '{ {8{16'h0003}}, 19'd24 };
    tbl[3] = '{ {8{16'h0004}}, 19'd32 };
    tbl[4] = '{ {8{16'h0005}}, 19'd40 };
    tbl[5] = '{ {8{16'h0006}}, 19'd48 };
    tbl[6] = '{ {8{16'h0007}}, 19'd56 };
    tbl[7] = '{ {8{16'h0008}}, 19'd64 };
    for (int k = 8; k < 16; k++) tbl[k] = '{ {8{16'h8000}}, 19'h40000 };
    tbl[16] = '{ 128'h7fff_8000_0001_ffff_0002_fffe_0003_fffd, 19'h7ffff };
    for (int k = 17; k < 24; k++) tbl[k] = '{ {8{16'h7fff}}, 19'h3fff8 };
    tot[0] = 22'd288;
    tot[1] = 22'h200000;
    tot[2] = 22'd1834951;
    for (int k = 0; k < 8; k++) mem[k] = '0;
    repeat (2) step;
    chk_reset_outs("reset");
    rst = 0;
    fill(0);
    full = 1;
    repeat (4) begin
      step;
      chk("en_low_busy", drain_busy, 0);
      chk("en_low_cen", sram_cen, 1);
    end
    en = 1;
    step;
    chk("en_rise_rd", sram_cen, 0);
    chk("en_rise_addr", sram_a, 0);
    run_batch(0, -1, 0, -1, 0);
    fill(1);
    full = 1;
    step;
    chk("b2b_idle", drain_busy, 0);
    chk("b2b_done_clr", drain_done, 0);
    step;
    chk("b2b_rd", sram_cen, 0);
    chk("b2b_addr", sram_a, 0);
    run_batch(1, -1, 0, -1, 1);
    chk_idle;
    start(2);
    run_batch(2, 3, 5, -1, 0);
    chk_idle;
    start(0);
    run_batch(0, -1, 0, 5, 0);
    start(0);
    run_batch(0, -1, 0, -1, 0);
    chk_idle;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
